// File: rtl/emif_avmm_burst_master.sv
// Avalon-MM burst exerciser: writes a seeded beat pattern over a window, reads it back, counts mismatches.
// Optional first-mismatch capture is enabled by defining EMIF_AVMM_BURST_MASTER_ERR_CAPTURE_EN.
module emif_avmm_burst_master #(
  parameter int          DATA_W       = 512,
  parameter int          ADDR_W       = 25,
  parameter int          BURST_W      = 7,
  parameter int          BURST_LEN    = 16,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
  input  logic                  pr_region_clk,
  input  logic                  usr_reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           num_bursts,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           err_count,
  output logic [31:0]           first_err_beat,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [BURST_W-1:0]    avm_burstcount,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_debugaccess
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_CMD, S_RD_WAIT, S_FIN} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] n);
    return {(DATA_W/32){n ^ PATTERN_SEED}};
  endfunction

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_base, r_addr;
  logic [15:0]         r_nbursts, r_burst_idx;
  logic [BURST_W-1:0]  r_bib;
  logic [31:0]         r_beat, r_err_count;
  logic                r_pass;

  logic w_start, w_wr_acc, w_rd_beat, w_step, w_last_beat, w_last_burst, w_mismatch;

  assign w_start      = (r_state == S_IDLE) && start;
  assign w_wr_acc     = (r_state == S_WR) && !avm_waitrequest;
  assign w_rd_beat    = (r_state == S_RD_WAIT) && avm_readdatavalid;
  assign w_step       = w_wr_acc || w_rd_beat;
  assign w_last_beat  = (r_bib == BURST_W'(BURST_LEN - 1));
  assign w_last_burst = (r_burst_idx == r_nbursts - 16'd1);
  assign w_mismatch   = w_rd_beat && (avm_readdata != pattern(r_beat));

  always_ff @(posedge pr_region_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    avm_write = 1'b0;
    avm_read  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = r_pass;
    case (r_state)
      S_IDLE:    if (start) w_next = (num_bursts == 16'd0) ? S_FIN : S_WR;
      S_WR: begin
        avm_write = 1'b1;
        busy      = 1'b1;
        if (w_wr_acc && w_last_beat && w_last_burst) w_next = S_RD_CMD;
      end
      S_RD_CMD: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        if (!avm_waitrequest) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        if (w_rd_beat && w_last_beat) w_next = w_last_burst ? S_FIN : S_RD_CMD;
      end
      S_FIN: begin
        done   = 1'b1;
        pass   = (r_err_count == 32'd0);
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Run configuration: captured once per accepted start, never reset.
  always_ff @(posedge pr_region_clk) begin
    if (w_start) begin
      r_base    <= base_addr;
      r_nbursts <= num_bursts;
    end
  end

  // Beat/burst walk shared by write and read phases; wraps back to the window start after the last burst.
  always_ff @(posedge pr_region_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_addr      <= '0;
      r_burst_idx <= '0;
      r_bib       <= '0;
      r_beat      <= '0;
      r_err_count <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr      <= base_addr;
        r_burst_idx <= '0;
        r_bib       <= '0;
        r_beat      <= '0;
        r_err_count <= '0;
        r_pass      <= 1'b0;
      end else if (w_step) begin
        if (w_last_beat) begin
          r_bib <= '0;
          if (w_last_burst) begin
            r_addr      <= r_base;
            r_burst_idx <= '0;
            r_beat      <= '0;
          end else begin
            r_addr      <= r_addr + ADDR_W'(BURST_LEN);
            r_burst_idx <= r_burst_idx + 16'd1;
            r_beat      <= r_beat + 32'd1;
          end
        end else begin
          r_bib  <= r_bib + BURST_W'(1);
          r_beat <= r_beat + 32'd1;
        end
      end
      if (w_mismatch) r_err_count <= sat_inc(r_err_count);
      if (r_state == S_FIN) r_pass <= (r_err_count == 32'd0);
    end
  end

`ifdef EMIF_AVMM_BURST_MASTER_ERR_CAPTURE_EN
  logic [31:0] r_first_err;
  // err_count is still zero on the first mismatching beat, since it only updates on the following edge.
  always_ff @(posedge pr_region_clk or negedge usr_reset_n) begin
    if (!usr_reset_n)                                 r_first_err <= '0;
    else if (w_start)                                 r_first_err <= '0;
    else if (w_mismatch && r_err_count == 32'd0)      r_first_err <= r_beat;
    else if (r_state == S_FIN && r_err_count == 32'd0) r_first_err <= 32'hFFFF_FFFF;
  end
  assign first_err_beat = r_first_err;
`else
  assign first_err_beat = 32'd0;
`endif

  assign err_count       = r_err_count;
  assign avm_address     = r_addr;
  assign avm_burstcount  = (avm_write || avm_read) ? BURST_W'(BURST_LEN) : '0;
  assign avm_writedata   = avm_write ? pattern(r_beat) : '0;
  assign avm_byteenable  = '1;
  assign avm_debugaccess = 1'b0;

endmodule

// File: tb/tb_emif_avmm_burst_master.sv
// Randomized bench for emif_avmm_burst_master: memory slave model plus pattern/error reference model.
module tb_emif_avmm_burst_master;
  localparam int          DATA_W = 512;
  localparam int          ADDR_W = 25;
  localparam int          BURST_W = 7;
  localparam int          BL = 16;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [15:0]         num_bursts = '0;
  logic                busy, done, pass;
  logic [31:0]         err_count, first_err_beat;
  logic                waitreq = 1'b0;
  logic [DATA_W-1:0]   rdata = '0;
  logic                rdv = 1'b0;
  logic [BURST_W-1:0]  avm_burstcount;
  logic [DATA_W-1:0]   avm_writedata;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_write, avm_read, avm_debugaccess;
  logic [DATA_W/8-1:0] avm_byteenable;

  always #5 clk = ~clk;

  emif_avmm_burst_master dut (
    .pr_region_clk(clk), .usr_reset_n(rst_n), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_beat(first_err_beat), .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .avm_readdatavalid(rdv), .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_debugaccess(avm_debugaccess)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'(n) ^ SEED;
    return {(DATA_W/32){w}};
  endfunction

  // Reference model / slave state
  logic [ADDR_W-1:0] m_base = '0;
  int  m_nb = 0, m_corrupt = -1;
  bit  m_stall = 0, model_on = 0, stale_poison = 0;
  int  wr_cnt = 0, rd_cmd_cnt = 0, rd_beat_cnt = 0, exp_err = 0, exp_first = -1, rd_delay = 0;
  logic [ADDR_W-1:0] burst_addr_q[$];
  logic [DATA_W-1:0] mem[int];
  logic [DATA_W-1:0] mem_ref[int];
  logic [DATA_W-1:0] rq[$];

  function automatic logic [ADDR_W-1:0] burst_base(input int b);
    return m_base + ADDR_W'(b * BL);
  endfunction

  // Slave and per-cycle compare; everything driven/sampled on the falling edge.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    if (model_on) begin
      chk("rd_wr_exclusive", {63'd0, avm_read & avm_write}, 64'd0);
      chk("err_count_track", {32'd0, err_count}, 64'(exp_err));
    end
    waitreq = m_stall ? 1'($urandom_range(0, 1)) : 1'b0;
    if (avm_write && !waitreq) begin
      a = burst_base(wr_cnt / BL);
      if (wr_cnt % BL == 0) burst_addr_q.push_back(avm_address);
      chk("wr_address", {39'd0, avm_address}, {39'd0, a});
      chk("wr_burstcount", {57'd0, avm_burstcount}, 64'(BL));
      chk("wr_byteenable_lo", avm_byteenable[63:0], {64{1'b1}});
      checks++;
      if (avm_writedata !== pat(wr_cnt)) begin
        errors++;
        $display("FAIL wr_data beat %0d: actual 0x%0h required 0x%0h", wr_cnt,
                 avm_writedata[31:0], pat(wr_cnt) & 512'hFFFF_FFFF);
      end
      mem[int'(a + ADDR_W'(wr_cnt % BL))] = avm_writedata;
      wr_cnt++;
    end
    if (avm_read && !waitreq) begin
      chk("rd_address", {39'd0, avm_address}, {39'd0, burst_base(rd_cmd_cnt)});
      chk("rd_burstcount", {57'd0, avm_burstcount}, 64'(BL));
      chk("rd_after_writes", 64'(wr_cnt), 64'(m_nb * BL));
      chk("rd_one_outstanding", 64'(rq.size()), 64'd0);
      for (int i = 0; i < BL; i++) begin
        a = avm_address + ADDR_W'(i);
        rq.push_back(mem.exists(int'(a)) ? mem[int'(a)] : '0);
      end
      rd_cmd_cnt++;
      rd_delay = 1;
    end
    rdv = 1'b0;
    rdata = {(DATA_W/32){32'($urandom)}};
    if (rd_delay > 0) rd_delay--;
    else if (rq.size() > 0 && (!m_stall || $urandom_range(0, 1) == 1)) begin
      d = rq.pop_front();
      if (stale_poison) d = ~d;
      else begin
        if (rd_beat_cnt == m_corrupt) d[0] = ~d[0];
        if (d !== pat(rd_beat_cnt)) begin
          exp_err++;
          if (exp_first < 0) exp_first = rd_beat_cnt;
        end
        rd_beat_cnt++;
      end
      rdata = d;
      rdv = 1'b1;
    end
  end

  function automatic logic [31:0] exp_first_val();
`ifdef EMIF_AVMM_BURST_MASTER_ERR_CAPTURE_EN
    return (exp_err == 0) ? 32'hFFFF_FFFF : 32'(exp_first);
`else
    return 32'd0;
`endif
  endfunction

  task automatic launch(input logic [ADDR_W-1:0] b, input int nb, input int corrupt, input bit stall);
    @(negedge clk);
    m_base = b; m_nb = nb; m_corrupt = corrupt; m_stall = stall; model_on = 0; stale_poison = 0;
    wr_cnt = 0; rd_cmd_cnt = 0; rd_beat_cnt = 0; exp_err = 0; exp_first = -1;
    burst_addr_q.delete();
    base_addr = b; num_bursts = 16'(nb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_on = 1;
    if (nb > 0) begin
      chk("busy_first_cycle", {63'd0, busy}, 64'd1);
      chk("write_first_cycle", {63'd0, avm_write}, 64'd1);
    end else begin
      chk("done_first_cycle", {63'd0, done}, 64'd1);
      chk("busy_zero_bursts", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic run(input logic [ADDR_W-1:0] b, input int nb, input int corrupt, input bit stall,
                     input bit timing);
    int cyc;
    bit got;
    logic exp_pass;
    launch(b, nb, corrupt, stall);
    cyc = 1;
    got = 0;
    while (cyc < 20000) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
      cyc++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual no done after %0d cycles required done", cyc);
      return;
    end
    exp_pass = (exp_err == 0);
    chk("final_err_count", {32'd0, err_count}, 64'(exp_err));
    chk("final_pass", {63'd0, pass}, {63'd0, exp_pass});
    chk("final_first_err", {32'd0, first_err_beat}, {32'd0, exp_first_val()});
    chk("write_beats", 64'(wr_cnt), 64'(nb * BL));
    chk("read_beats", 64'(rd_beat_cnt), 64'(nb * BL));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    if (timing) chk("run_cycles", 64'(cyc), 64'(nb * BL + nb * (1 + BL) + 1));
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("pass_held", {63'd0, pass}, {63'd0, exp_pass});
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int diff, cnt;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pass", {63'd0, pass}, 64'd0);
    chk("rst_err_count", {32'd0, err_count}, 64'd0);
    chk("rst_first_err", {32'd0, first_err_beat}, 64'd0);
    chk("rst_write", {63'd0, avm_write}, 64'd0);
    chk("rst_read", {63'd0, avm_read}, 64'd0);
    chk("rst_address", {39'd0, avm_address}, 64'd0);
    chk("rst_burstcount", {57'd0, avm_burstcount}, 64'd0);
    chk("rst_writedata_zero", {63'd0, |avm_writedata}, 64'd0);
    chk("rst_byteenable_ones", {63'd0, &avm_byteenable}, 64'd1);
    chk("rst_debugaccess", {63'd0, avm_debugaccess}, 64'd0);
    rst_n = 1'b1;

    // Zero-wait baseline with literal burst addresses
    run(25'd0, 4, -1, 0, 1);
    chk("baseline_nbursts", 64'(burst_addr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < burst_addr_q.size(); i++)
      chk("baseline_burst_addr", {39'd0, burst_addr_q[i]}, 64'(16 * i));
    chk("baseline_pass_literal", {63'd0, pass}, 64'd1);

    // Random stalls must leave identical memory contents
    mem_ref = mem;
    mem.delete();
    run(25'd0, 4, -1, 1, 0);
    diff = 0;
    foreach (mem_ref[k]) if (!mem.exists(k) || mem[k] !== mem_ref[k]) diff++;
    chk("stall_mem_size", 64'(mem.size()), 64'(mem_ref.size()));
    chk("stall_mem_equal", 64'(diff), 64'd0);

    // Corrupted read beat 37
    run(25'd0, 4, 37, 0, 0);
    chk("corrupt_err_literal", {32'd0, err_count}, 64'd1);
    chk("corrupt_pass_literal", {63'd0, pass}, 64'd0);
`ifdef EMIF_AVMM_BURST_MASTER_ERR_CAPTURE_EN
    chk("corrupt_first_literal", {32'd0, first_err_beat}, 64'd37);
`else
    chk("corrupt_first_literal", {32'd0, first_err_beat}, 64'd0);
`endif

    // Address wrap at the top of the space
    run(25'h1FF_FFF0, 2, -1, 0, 0);
    chk("wrap_nbursts", 64'(burst_addr_q.size()), 64'd2);
    if (burst_addr_q.size() == 2) begin
      chk("wrap_addr0", {39'd0, burst_addr_q[0]}, 64'h1FF_FFF0);
      chk("wrap_addr1", {39'd0, burst_addr_q[1]}, 64'd0);
    end

    // Zero bursts
    run(25'h123, 0, -1, 0, 1);
    chk("zero_pass_literal", {63'd0, pass}, 64'd1);

    // Reset in the middle of the read phase, stale data afterwards, then a clean rerun
    launch(25'h40, 4, -1, 0);
    cnt = 0;
    while (rd_beat_cnt < 20 && cnt < 5000) begin @(negedge clk); cnt++; end
    chk("midrun_reached_reads", {63'd0, rd_beat_cnt >= 20}, 64'd1);
    #2;
    rst_n = 1'b0;
    model_on = 0;
    stale_poison = 1;
    #1;
    chk("async_rst_read", {63'd0, avm_read}, 64'd0);
    chk("async_rst_write", {63'd0, avm_write}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while ((rq.size() > 0 || rd_delay > 0) && cnt < 100) begin @(negedge clk); cnt++; end
    repeat (2) @(negedge clk);
    chk("stale_err_count", {32'd0, err_count}, 64'd0);
    chk("stale_busy", {63'd0, busy}, 64'd0);
    chk("stale_done", {63'd0, done}, 64'd0);
    chk("stale_read", {63'd0, avm_read}, 64'd0);
    stale_poison = 0;
    run(25'h40, 4, -1, 0, 1);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      int nb;
      nb = $urandom_range(1, 5);
      run(25'($urandom), nb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb * BL - 1)) : -1,
          1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
